// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore FSM control unit for a stack-based multicycle datapath
module multicycle_controller #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [2:0]       opc,
    output logic [1:0]       ALUOP,
    output logic             pcWriteUnCond,
    output logic             pcWriteCond,
    output logic             IorD,
    output logic             memRead,
    output logic             memWrite,
    output logic             IRWrite,
    output logic             MtoS,
    output logic             push,
    output logic             pop,
    output logic             tos,
    output logic             ldA,
    output logic             ldB,
    output logic             srcA,
    output logic             srcB,
    output logic             pcSrc,
    output logic             busy,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_IDLE, S_IF, S_ID, S_POPA, S_POPB, S_EX, S_WB,
        S_MRD, S_PWB, S_MWR, S_JMP, S_JZ
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   w_retire;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            retired <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire)
                retired <= retired + 1'b1;
        end
    end

    // Every terminal state returns to IF, so retirement is simply "in a terminal state".
    always_comb begin
        w_retire = 1'b0;
        case (r_state)
            S_WB, S_PWB, S_MWR, S_JMP, S_JZ: w_retire = 1'b1;
            default:                         w_retire = 1'b0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: w_next = run ? S_IF : S_IDLE;
            S_IF:   w_next = S_ID;
            S_ID: begin
                case (opc)
                    3'b100:  w_next = S_MRD;
                    3'b110:  w_next = S_JMP;
                    3'b111:  w_next = S_JZ;
                    default: w_next = S_POPA;
                endcase
            end
            S_POPA: begin
                case (opc)
                    3'b011:  w_next = S_EX;
                    3'b101:  w_next = S_MWR;
                    default: w_next = S_POPB;
                endcase
            end
            S_POPB: w_next = S_EX;
            S_EX:   w_next = S_WB;
            S_MRD:  w_next = S_PWB;
            S_WB, S_PWB, S_MWR, S_JMP, S_JZ: w_next = S_IF;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        ALUOP         = 2'b00;
        pcWriteUnCond = 1'b0;
        pcWriteCond   = 1'b0;
        IorD          = 1'b0;
        memRead       = 1'b0;
        memWrite      = 1'b0;
        IRWrite       = 1'b0;
        MtoS          = 1'b0;
        push          = 1'b0;
        pop           = 1'b0;
        tos           = 1'b0;
        ldA           = 1'b0;
        ldB           = 1'b0;
        srcA          = 1'b0;
        srcB          = 1'b0;
        pcSrc         = 1'b0;
        busy          = (r_state != S_IDLE);
        case (r_state)
            S_IF: begin
                memRead       = 1'b1;
                IRWrite       = 1'b1;
                srcA          = 1'b1;
                srcB          = 1'b1;
                pcWriteUnCond = 1'b1;
            end
            S_ID:   tos = 1'b1;
            S_POPA: begin
                tos = 1'b1;
                ldA = 1'b1;
                pop = 1'b1;
            end
            S_POPB: begin
                tos = 1'b1;
                ldB = 1'b1;
                pop = 1'b1;
            end
            S_EX:   ALUOP = opc[1:0];
            S_WB:   push = 1'b1;
            S_MRD: begin
                IorD    = 1'b1;
                memRead = 1'b1;
            end
            S_PWB: begin
                MtoS = 1'b1;
                push = 1'b1;
            end
            S_MWR: begin
                IorD     = 1'b1;
                memWrite = 1'b1;
            end
            S_JMP: begin
                pcSrc         = 1'b1;
                pcWriteUnCond = 1'b1;
            end
            S_JZ: begin
                pcSrc       = 1'b1;
                pcWriteCond = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - scoreboard bench for multicycle_controller
module tb_multicycle_controller;

    localparam int CW = 4;

    localparam int S_IDLE = 0, S_IF = 1, S_ID = 2, S_POPA = 3, S_POPB = 4, S_EX = 5,
                   S_WB = 6, S_MRD = 7, S_PWB = 8, S_MWR = 9, S_JMP = 10, S_JZ = 11;

    logic          clk = 1'b0;
    logic          rst, run;
    logic [2:0]    opc;
    logic [1:0]    ALUOP;
    logic          pcWriteUnCond, pcWriteCond, IorD, memRead, memWrite, IRWrite, MtoS;
    logic          push, pop, tos, ldA, ldB, srcA, srcB, pcSrc, busy;
    logic [CW-1:0] retired;

    multicycle_controller #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .run(run), .opc(opc), .ALUOP(ALUOP),
        .pcWriteUnCond(pcWriteUnCond), .pcWriteCond(pcWriteCond), .IorD(IorD),
        .memRead(memRead), .memWrite(memWrite), .IRWrite(IRWrite), .MtoS(MtoS),
        .push(push), .pop(pop), .tos(tos), .ldA(ldA), .ldB(ldB), .srcA(srcA),
        .srcB(srcB), .pcSrc(pcSrc), .busy(busy), .retired(retired)
    );

    always #5 clk = ~clk;

    // {ALUOP, pcWU, pcWC, IorD, memRead, memWrite, IRWrite, MtoS, push, pop, tos, ldA, ldB, srcA, srcB, pcSrc, busy}
    logic [17:0] obs;
    assign obs = {ALUOP, pcWriteUnCond, pcWriteCond, IorD, memRead, memWrite, IRWrite, MtoS,
                  push, pop, tos, ldA, ldB, srcA, srcB, pcSrc, busy};

    typedef struct {
        logic [17:0]   vec;
        logic [CW-1:0] ret;
        int            st;
    } exp_t;

    exp_t          sb[$];
    logic [CW-1:0] exp_ret = '0;
    int            n_vec = 0;
    int            n_err = 0;

    function automatic logic [17:0] vec_of(input int s, input logic [2:0] op);
        logic [17:0] v;
        v = 18'd0;
        case (s)
            S_IF:   begin v[15] = 1; v[12] = 1; v[10] = 1; v[3] = 1; v[2] = 1; end
            S_ID:   v[6] = 1;
            S_POPA: begin v[6] = 1; v[5] = 1; v[7] = 1; end
            S_POPB: begin v[6] = 1; v[4] = 1; v[7] = 1; end
            S_EX:   v[17:16] = op[1:0];
            S_WB:   v[8] = 1;
            S_MRD:  begin v[13] = 1; v[12] = 1; end
            S_PWB:  begin v[9] = 1; v[8] = 1; end
            S_MWR:  begin v[13] = 1; v[11] = 1; end
            S_JMP:  begin v[1] = 1; v[15] = 1; end
            S_JZ:   begin v[1] = 1; v[14] = 1; end
            default: ;
        endcase
        if (s != S_IDLE) v[0] = 1;
        return v;
    endfunction

    task automatic push_instr(input logic [2:0] op, input int limit);
        int seq[$];
        seq = {S_IF, S_ID};
        case (op)
            3'b000, 3'b001, 3'b010: seq = {seq, S_POPA, S_POPB, S_EX, S_WB};
            3'b011: seq = {seq, S_POPA, S_EX, S_WB};
            3'b100: seq = {seq, S_MRD, S_PWB};
            3'b101: seq = {seq, S_POPA, S_MWR};
            3'b110: seq = {seq, S_JMP};
            default: seq = {seq, S_JZ};
        endcase
        for (int i = 0; i < seq.size() && i < limit; i++)
            sb.push_back('{vec_of(seq[i], op), exp_ret, seq[i]});
        if (limit >= seq.size())
            exp_ret = exp_ret + 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input exp_t e);
        n_vec++;
        assert (obs === e.vec) else begin
            n_err++;
            $error("FAIL ctl st=%0d observed=%b expected=%b", e.st, obs, e.vec);
        end
        n_vec++;
        assert (retired === e.ret) else begin
            n_err++;
            $error("FAIL retired st=%0d observed=%0d expected=%0d", e.st, retired, e.ret);
        end
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            step();
            check(e);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0] prog[$];
        rst = 1'b1;
        run = 1'b1;
        opc = 3'b000;
        step();
        step();
        check('{18'd0, '0, S_IDLE});
        rst = 1'b0;

        prog = {3'b100, 3'b001, 3'b011, 3'b111, 3'b110, 3'b101, 3'b010, 3'b000};
        foreach (prog[k]) begin
            opc = prog[k];
            push_instr(prog[k], 99);
            drain();
        end

        // Reset lands on the edge leaving EX of an ADD: no WB may follow.
        opc = 3'b000;
        push_instr(3'b000, 5);
        drain();
        rst = 1'b1;
        run = 1'b0;
        step();
        exp_ret = '0;
        check('{18'd0, '0, S_IDLE});
        rst = 1'b0;
        step();
        check('{18'd0, '0, S_IDLE});
        step();
        check('{18'd0, '0, S_IDLE});

        // Seventeen jumps: the 17th IF shows the counter wrapped to 0.
        run = 1'b1;
        opc = 3'b110;
        for (int j = 0; j < 17; j++) begin
            push_instr(3'b110, 99);
            drain();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
